ram_access_ctrl: RTL and testbench
==================================

Name: ram_access_ctrl

Overview:
- Synchronous front end that sits directly upstream of the asynchronous 64K x 8 RAM.
- Converts a single-cycle request/acknowledge interface (CPU core, loader or test harness) into properly sequenced RAM strobes: address/data setup, chip-select/output-enable or write strobe, then hold.
- The RAM writes on level (cs_n low and rw_n low, sensitive to data/address), so this block guarantees that address and data are stable before cs_n falls and after it rises.
- Programmable wait-state counts allow slower memory timing.

Parameters:
- ADDR_WIDTH, 16, RAM address width (matches 64K RAM).
- DATA_WIDTH, 8, data width.
- SETUP_CYCLES, 1, cycles address/data are driven before the strobe (legal range >=1).
- STROBE_CYCLES, 2, cycles cs_n is held low (legal range >=1).
- HOLD_CYCLES, 1, cycles address/data are held after the strobe (legal range >=1).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  access request, sampled only in IDLE.
- we  input  1  1=write, 0=read; latched with req.
- addr  input  ADDR_WIDTH  access address; latched with req.
- wdata  input  DATA_WIDTH  write data; latched with req.
- rdata  output  DATA_WIDTH  read data, registered.
- ack  output  1  one-cycle completion pulse.
- busy  output  1  high whenever state != IDLE.
- mem_address  output  ADDR_WIDTH  to RAM address.
- mem_data  inout  DATA_WIDTH  to RAM data; driven only during writes, else high-Z.
- cs_n  output  1  RAM chip select, active low.
- rw_n  output  1  RAM read/write, low = write.
- oe_n  output  1  RAM output enable, active low.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- All outputs come from flops. No combinational strobe decode, so strobes are glitch-free.
- Reset values:
  - cs_n=1, rw_n=1, oe_n=1.
  - mem_data=Z.
  - mem_address=0, rdata=0, ack=0, busy=0.
  - state=IDLE, wait counter=0.
- FSM states: IDLE, SETUP, STROBE, HOLD. A single down-counter is loaded on each state entry.
- IDLE:
  - Strobes are inactive and the bus is released.
  - On an edge with req=1: latch addr, we and wdata; drive mem_address; for writes, start driving mem_data; go to SETUP.
- SETUP:
  - Lasts SETUP_CYCLES cycles with cs_n=1.
  - Then go to STROBE: cs_n=0; a read sets oe_n=0, rw_n=1; a write sets oe_n=1, rw_n=0.
- STROBE:
  - Lasts STROBE_CYCLES cycles.
  - For a read, rdata captures mem_data on the edge that leaves STROBE.
  - On leaving STROBE: cs_n=1, oe_n=1, rw_n=1.
- HOLD:
  - Lasts HOLD_CYCLES cycles. mem_address is held and write data is still driven.
  - On exit: release mem_data, go to IDLE, and assert ack for exactly one cycle.
- Latency: ack is high in cycle SETUP+STROBE+HOLD after the accept edge (4 cycles with defaults).
- Back-to-back accesses:
  - req is sampled in the IDLE cycle in which ack is high, so it can be accepted there.
  - Minimum access period is SETUP+STROBE+HOLD+1 cycles (5 with defaults).
- While busy:
  - req is ignored and not queued.
  - Changes on addr, we and wdata have no effect.
- rdata holds the last read value. Writes never change it.
- Reset mid-access:
  - At the next edge all strobes go inactive, mem_data goes to Z, and state returns to IDLE.
  - No ack is issued and rdata is cleared to 0. A write in progress may or may not have landed.
- Reset has priority over a simultaneous req.
- Illegal parameters: any *_CYCLES value of 0 triggers a simulation $error at time 0.

Test Plan:
- Assert reset for 2 cycles -> cs_n=rw_n=oe_n=1, mem_data=Z, ack=0, busy=0, rdata=0x00.
- Write 0xA5 to 0x1234 with defaults -> mem_data=0xA5 from accept+1 through HOLD; cs_n and rw_n low for exactly 2 cycles, never low while address/data change; ack high in cycle 4; RAM[0x1234]=0xA5.
- Read 0x1234 afterwards -> oe_n and cs_n low for 2 cycles, rw_n=1, mem_data never driven by the block; rdata=0xA5 no later than the ack cycle.
- Hold req=1 with alternating write 0x10@0x0200 and read @0x0200 -> ack every 5 cycles; the read returns 0x10; a req change during busy is ignored.
- Assert reset during the second STROBE cycle of a write -> next cycle cs_n=1, rw_n=1, mem_data=Z, busy=0, no ack; a following read completes normally.
- Set SETUP=2, STROBE=3, HOLD=2 and change addr mid-access -> latched address used; cs_n low for 3 cycles; ack 7 cycles after accept.

Source files
------------

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
//   Synchronous front end for an asynchronous 64K x 8 RAM. It turns a
//   single-cycle req/ack handshake into a sequenced access:
//     setup (address/data stable, cs_n high) -> strobe (cs_n low)
//     -> hold (address/data still stable) -> ack.
//   Every output comes straight from a flop, so the strobes are glitch-free.
//
// Ports
//   clk, reset   : clock and synchronous active-high reset
//   req, we      : request (sampled only while idle) and write select
//   addr, wdata  : access address and write data, latched with req
//   rdata        : last read value, registered
//   ack          : one-cycle completion pulse
//   busy         : high while an access is in progress
//   mem_address  : RAM address
//   mem_data     : RAM data bus, driven only while a write is in progress
//   cs_n, rw_n, oe_n : RAM chip select, read/write (low = write), output enable
module ram_access_ctrl #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ack,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_address,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  cs_n,
  output logic                  rw_n,
  output logic                  oe_n
);

  // Elaboration-time rejection of zero-length phases.
  if (SETUP_CYCLES < 1) begin : g_bad_setup
    $error("ram_access_ctrl: SETUP_CYCLES must be >= 1");
  end
  if (STROBE_CYCLES < 1) begin : g_bad_strobe
    $error("ram_access_ctrl: STROBE_CYCLES must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("ram_access_ctrl: HOLD_CYCLES must be >= 1");
  end

  localparam int MAX_CYCLES =
    (SETUP_CYCLES > STROBE_CYCLES) ?
      ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES) :
      ((STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES);
  localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic                  we_q;
  logic                  drive_en;
  logic [DATA_WIDTH-1:0] wdata_q;

  // The bus is released whenever no write is in flight, including after reset.
  assign mem_data = drive_en ? wdata_q : {DATA_WIDTH{1'bz}};

  // Write data only needs to follow req; it is never observed unless drive_en is set.
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      wdata_q <= wdata;
    end
  end

  // The counter is loaded with (length-1) on each state entry and the state
  // advances on the edge where it reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      drive_en    <= 1'b0;
      cs_n        <= 1'b1;
      rw_n        <= 1'b1;
      oe_n        <= 1'b1;
      mem_address <= '0;
      rdata       <= '0;
      ack         <= 1'b0;
      busy        <= 1'b0;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            we_q        <= we;
            mem_address <= addr;
            drive_en    <= we;
            busy        <= 1'b1;
            cnt         <= SETUP_LOAD;
            state       <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            cs_n  <= 1'b0;
            rw_n  <= ~we_q;
            oe_n  <= we_q;
            cnt   <= STROBE_LOAD;
            state <= STROBE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            // RAM is still driving on this edge; strobes drop after it.
            if (!we_q) begin
              rdata <= mem_data;
            end
            cs_n  <= 1'b1;
            rw_n  <= 1'b1;
            oe_n  <= 1'b1;
            cnt   <= HOLD_LOAD;
            state <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            drive_en <= 1'b0;
            busy     <= 1'b0;
            ack      <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
module tb_ram_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, req_b;
  logic        we;
  logic [15:0] addr;
  logic [7:0]  wdata;

  logic [7:0]  rdata_a, rdata_b;
  logic        ack_a, ack_b, busy_a, busy_b;
  logic [15:0] mem_address_a, mem_address_b;
  wire  [7:0]  mem_data_a, mem_data_b;
  logic        cs_n_a, cs_n_b, rw_n_a, rw_n_b, oe_n_a, oe_n_b;

  always #5 clk = ~clk;

  // Instance a: default timing. Instance b: setup 2, strobe 3, hold 2.
  ram_access_ctrl dut_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_a), .ack(ack_a), .busy(busy_a), .mem_address(mem_address_a),
    .mem_data(mem_data_a), .cs_n(cs_n_a), .rw_n(rw_n_a), .oe_n(oe_n_a)
  );

  ram_access_ctrl #(.SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(2)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_b), .ack(ack_b), .busy(busy_b), .mem_address(mem_address_b),
    .mem_data(mem_data_b), .cs_n(cs_n_b), .rw_n(rw_n_b), .oe_n(oe_n_b)
  );

  // Released bus reads as all ones.
  for (genvar i = 0; i < 8; i++) begin : g_pull
    pullup (mem_data_a[i]);
    pullup (mem_data_b[i]);
  end

  // Asynchronous RAM models: unwritten locations hold a fixed address pattern.
  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  logic [7:0] ram_a [65536];
  logic [7:0] ram_b [65536];
  bit         wr_a  [65536];
  bit         wr_b  [65536];
  logic [7:0] rd_a, rd_b;

  always_comb begin
    rd_a = wr_a[mem_address_a] ? ram_a[mem_address_a] : init_val(mem_address_a);
    rd_b = wr_b[mem_address_b] ? ram_b[mem_address_b] : init_val(mem_address_b);
  end

  assign mem_data_a = (!cs_n_a && !oe_n_a && rw_n_a) ? rd_a : 8'bz;
  assign mem_data_b = (!cs_n_b && !oe_n_b && rw_n_b) ? rd_b : 8'bz;

  always @(negedge clk) begin
    if (!cs_n_a && !rw_n_a) begin
      ram_a[mem_address_a] <= mem_data_a;
      wr_a[mem_address_a]  <= 1'b1;
    end
    if (!cs_n_b && !rw_n_b) begin
      ram_b[mem_address_b] <= mem_data_b;
      wr_b[mem_address_b]  <= 1'b1;
    end
  end

  // Reference: expected memory contents and last read value per instance.
  logic [7:0] ref_mem [int];
  logic [7:0] last_rd [2];
  longint     ack_t;
  int         n_cmp = 0;
  int         n_bad = 0;

  function automatic logic [7:0] exp_rd(input int s, input logic [15:0] a);
    int key;
    key = s * 65536 + int'(a);
    return ref_mem.exists(key) ? ref_mem[key] : init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One access on instance s, checked cycle by cycle from the accept edge
  // (n = 0) up to the ack cycle (n = S+T+H). With scramble set, req and the
  // request fields are randomised while busy and must have no effect.
  task automatic access(input int s, input logic w, input logic [15:0] a,
                        input logic [7:0] d, input bit scramble);
    int S, T, H, L;
    logic strobe;
    logic [7:0] rv;
    logic o_busy, o_ack, o_cs, o_rw, o_oe;
    logic [15:0] o_addr;
    logic [7:0] o_md, o_rdata;
    S = (s == 1) ? 2 : 1;
    T = (s == 1) ? 3 : 2;
    H = (s == 1) ? 2 : 1;
    L = S + T + H;
    rv = exp_rd(s, a);
    we = w; addr = a; wdata = d;
    if (s == 1) req_b = 1'b1; else req_a = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n <= L; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      o_busy  = (s == 1) ? busy_b : busy_a;
      o_ack   = (s == 1) ? ack_b : ack_a;
      o_cs    = (s == 1) ? cs_n_b : cs_n_a;
      o_rw    = (s == 1) ? rw_n_b : rw_n_a;
      o_oe    = (s == 1) ? oe_n_b : oe_n_a;
      o_addr  = (s == 1) ? mem_address_b : mem_address_a;
      o_md    = (s == 1) ? mem_data_b : mem_data_a;
      o_rdata = (s == 1) ? rdata_b : rdata_a;
      strobe  = (n >= S) && (n < S + T);
      chk("busy", 32'(o_busy), 32'(n < L));
      chk("ack", 32'(o_ack), 32'(n == L));
      chk("cs_n", 32'(o_cs), 32'(!strobe));
      chk("rw_n", 32'(o_rw), 32'(!(strobe && w)));
      chk("oe_n", 32'(o_oe), 32'(!(strobe && !w)));
      if (n < L) chk("mem_address", 32'(o_addr), 32'(a));
      if (w) chk("mem_data_wr", 32'(o_md), (n < L) ? 32'(d) : 32'hFF);
      else   chk("mem_data_rd", 32'(o_md), strobe ? 32'(rv) : 32'hFF);
      if (n == L) begin
        ack_t = longint'($time);
        chk("rdata", 32'(o_rdata), w ? 32'(last_rd[s]) : 32'(rv));
      end
      if (n < L && scramble) begin
        if (s == 1) req_b = 1'($urandom); else req_a = 1'($urandom);
        we = 1'($urandom); addr = 16'($urandom); wdata = 8'($urandom);
      end else begin
        req_a = 1'b0; req_b = 1'b0;
      end
    end
    if (w) begin
      ref_mem[s * 65536 + int'(a)] = d;
      chk("ram_content", (s == 1) ? 32'(ram_b[a]) : 32'(ram_a[a]), 32'(d));
    end else begin
      last_rd[s] = rv;
    end
  endtask

  task automatic idle(input int k);
    req_a = 1'b0; req_b = 1'b0;
    repeat (k) begin
      @(posedge clk); #1;
      chk("idle_ack", 32'({ack_a, ack_b}), 32'h0);
      chk("idle_busy", 32'({busy_a, busy_b}), 32'h0);
    end
  endtask

  initial begin
    longint prev_t;
    logic [15:0] ra;
    reset = 1'b1; req_a = 1'b0; req_b = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    last_rd[0] = 8'h00; last_rd[1] = 8'h00;
    ack_t = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_strobes", 32'({cs_n_a, rw_n_a, oe_n_a}), 32'h7);
    chk("rst_bus", 32'(mem_data_a), 32'hFF);
    chk("rst_ack_busy", 32'({ack_a, busy_a}), 32'h0);
    chk("rst_rdata", 32'(rdata_a), 32'h0);
    chk("rst_addr", 32'(mem_address_a), 32'h0);
    chk("rst_b", 32'({cs_n_b, rw_n_b, oe_n_b, ack_b, busy_b}), 32'h1C);
    reset = 1'b0;
    idle(1);

    // Directed write then read
    access(0, 1'b1, 16'h1234, 8'hA5, 1'b0);
    idle(1);
    access(0, 1'b0, 16'h1234, 8'h00, 1'b0);
    idle(2);

    // Back-to-back alternating write/read with req held and inputs disturbed
    for (int i = 0; i < 3; i++) begin
      prev_t = ack_t;
      access(0, 1'b1, 16'h0200, 8'h10 + 8'(i), 1'b1);
      if (i > 0) chk("b2b_period_w", 32'(ack_t - prev_t), 32'd50);
      prev_t = ack_t;
      access(0, 1'b0, 16'h0200, 8'h00, 1'b1);
      chk("b2b_period_r", 32'(ack_t - prev_t), 32'd50);
    end
    idle(1);

    // Reset during the second strobe cycle of a write, with req also high
    we = 1'b1; addr = 16'h3333; wdata = 8'h5A; req_a = 1'b1;
    @(posedge clk); #1;
    req_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_cs_low", 32'({cs_n_a, rw_n_a}), 32'h0);
    reset = 1'b1; req_a = 1'b1;
    @(posedge clk); #1;
    chk("mid_strobes", 32'({cs_n_a, rw_n_a, oe_n_a}), 32'h7);
    chk("mid_bus", 32'(mem_data_a), 32'hFF);
    chk("mid_busy_ack", 32'({busy_a, ack_a}), 32'h0);
    chk("mid_rdata", 32'(rdata_a), 32'h0);
    reset = 1'b0; req_a = 1'b0;
    last_rd[0] = 8'h00; last_rd[1] = 8'h00;
    idle(2);
    access(0, 1'b0, 16'h1234, 8'h00, 1'b0);
    idle(1);

    // Slow-timing instance: latched address survives mid-access changes
    access(1, 1'b1, 16'h0ABC, 8'hC3, 1'b1);
    idle(1);
    access(1, 1'b0, 16'h0ABC, 8'h00, 1'b1);
    idle(1);

    // Randomised traffic on both instances over a small address window
    for (int i = 0; i < 24; i++) begin
      ra = 16'h4000 + 16'($urandom_range(0, 15));
      access(i % 3 == 2 ? 1 : 0, 1'($urandom), ra, 8'($urandom), 1'($urandom));
      idle($urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
